// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the cpu_loader stream loader: command codes,
// header field positions, the FSM state type and the range-check helper.
`timescale 1ns/1ps
package cpu_loader_pkg;

  localparam logic [1:0] CMD_LOAD_I  = 2'b00;
  localparam logic [1:0] CMD_LOAD_D  = 2'b01;
  localparam logic [1:0] CMD_RUN     = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  localparam int HDR_CMD_MSB  = 31;
  localparam int HDR_CMD_LSB  = 30;
  localparam int HDR_BASE_MSB = 29;
  localparam int HDR_BASE_LSB = 16;
  localparam int HDR_N_MSB    = 15;
  localparam int HDR_N_LSB    = 0;

  localparam int BASE_W = 14;
  localparam int CNT_W  = 16;
  // base + N never exceeds 17 bits, so word indices live in this width
  localparam int WIDX_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_I    = 3'd1,
    ST_LOAD_D_LO = 3'd2,
    ST_LOAD_D_HI = 3'd3,
    ST_RUN       = 3'd4,
    ST_ERR       = 3'd5
  } state_e;

  // True when the byte just past the last word lies beyond the memory.
  function automatic logic range_bad(input logic [BASE_W-1:0] base,
                                     input logic [CNT_W-1:0]  n,
                                     input int unsigned       word_shift,
                                     input int unsigned       addr_w);
    logic [WIDX_W-1:0] end_idx;
    logic [63:0]       end_byte;
    end_idx  = {3'b000, base} + {1'b0, n};
    end_byte = {47'd0, end_idx} << word_shift;
    return end_byte > (64'd1 << addr_w);
  endfunction

endpackage

// File: rtl/cpu_loader.sv
// Streaming loader: decodes header words, writes payload into the cpu's
// instruction/data memories through the *_ext port sets and runs the cpu
// for a programmed number of cycles. All outputs are registered.
`timescale 1ns/1ps
module cpu_loader
  import cpu_loader_pkg::*;
#(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_e            state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;   // current word index (imem or dmem)
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // words left to load / cycles left to run
  logic [31:0]       lo_q, lo_d;       // low half of the pending dmem word

  logic        s_ready_q, s_ready_d;
  logic [63:0] addr_ext_q, addr_ext_d;
  logic        wen_ext_q, wen_ext_d;
  logic [31:0] wdata_ext_q, wdata_ext_d;
  logic [63:0] addr_ext_2_q, addr_ext_2_d;
  logic        wen_ext_2_q, wen_ext_2_d;
  logic [63:0] wdata_ext_2_q, wdata_ext_2_d;
  logic        enable_q, enable_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic              accept_s;
  logic [1:0]        hdr_cmd_s;
  logic [BASE_W-1:0] hdr_base_s;
  logic [CNT_W-1:0]  hdr_n_s;

  assign accept_s   = s_valid && s_ready_q;
  assign hdr_cmd_s  = s_data[HDR_CMD_MSB:HDR_CMD_LSB];
  assign hdr_base_s = s_data[HDR_BASE_MSB:HDR_BASE_LSB];
  assign hdr_n_s    = s_data[HDR_N_MSB:HDR_N_LSB];

  // Next-state, datapath and registered-output decode for the loader FSM.
  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    cnt_d         = cnt_q;
    lo_d          = lo_q;
    addr_ext_d    = addr_ext_q;
    wen_ext_d     = 1'b0;
    wdata_ext_d   = wdata_ext_q;
    addr_ext_2_d  = addr_ext_2_q;
    wen_ext_2_d   = 1'b0;
    wdata_ext_2_d = wdata_ext_2_q;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (hdr_cmd_s)
            CMD_LOAD_I: begin
              if (hdr_n_s == 16'd0) begin
                state_d = ST_IDLE;
              end else if (range_bad(hdr_base_s, hdr_n_s, 32'd2, IMEM_ADDR_W)) begin
                state_d = ST_ERR;
              end else begin
                state_d = ST_LOAD_I;
                widx_d  = {3'b000, hdr_base_s};
                cnt_d   = hdr_n_s;
              end
            end
            CMD_LOAD_D: begin
              if (hdr_n_s == 16'd0) begin
                state_d = ST_IDLE;
              end else if (range_bad(hdr_base_s, hdr_n_s, 32'd3, DMEM_ADDR_W)) begin
                state_d = ST_ERR;
              end else begin
                state_d = ST_LOAD_D_LO;
                widx_d  = {3'b000, hdr_base_s};
                cnt_d   = hdr_n_s;
              end
            end
            CMD_RUN: begin
              state_d = ST_RUN;
              cnt_d   = hdr_n_s;
            end
            CMD_ILLEGAL: state_d = ST_ERR;
            default:     state_d = ST_ERR;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_I: begin
        if (accept_s) begin
          wen_ext_d   = 1'b1;
          addr_ext_d  = {45'd0, widx_q, 2'b00};
          wdata_ext_d = s_data;
          widx_d      = widx_q + 17'd1;
          cnt_d       = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD_I;
          end
        end else begin
          state_d = ST_LOAD_I;
        end
      end
      ST_LOAD_D_LO: begin
        if (accept_s) begin
          lo_d    = s_data;
          state_d = ST_LOAD_D_HI;
        end else begin
          state_d = ST_LOAD_D_LO;
        end
      end
      ST_LOAD_D_HI: begin
        if (accept_s) begin
          wen_ext_2_d   = 1'b1;
          addr_ext_2_d  = {44'd0, widx_q, 3'b000};
          wdata_ext_2_d = {s_data, lo_q};
          widx_d        = widx_q + 17'd1;
          cnt_d         = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD_D_LO;
          end
        end else begin
          state_d = ST_LOAD_D_HI;
        end
      end
      ST_RUN: begin
        // A zero count means run until reset
        if (cnt_q == 16'd0) begin
          state_d = ST_RUN;
        end else if (cnt_q == 16'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q - 16'd1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase

    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD_I) ||
                (state_d == ST_LOAD_D_LO) || (state_d == ST_LOAD_D_HI);
    enable_d  = (state_d == ST_RUN);
    busy_d    = (state_d != ST_IDLE);
    error_d   = error_q || (state_d == ST_ERR);
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= ST_IDLE;
      widx_q        <= 17'd0;
      cnt_q         <= 16'd0;
      lo_q          <= 32'd0;
      s_ready_q     <= 1'b0;
      addr_ext_q    <= 64'd0;
      wen_ext_q     <= 1'b0;
      wdata_ext_q   <= 32'd0;
      addr_ext_2_q  <= 64'd0;
      wen_ext_2_q   <= 1'b0;
      wdata_ext_2_q <= 64'd0;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      cnt_q         <= cnt_d;
      lo_q          <= lo_d;
      s_ready_q     <= s_ready_d;
      addr_ext_q    <= addr_ext_d;
      wen_ext_q     <= wen_ext_d;
      wdata_ext_q   <= wdata_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wen_ext_2_q   <= wen_ext_2_d;
      wdata_ext_2_q <= wdata_ext_2_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = wdata_ext_2_q;
  assign enable      = enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_cpu_loader.sv
// Self-checking bench for cpu_loader: a write scoreboard fed by a
// command-level model, per-cycle invariant checks and directed scenarios.
`timescale 1ns/1ps
module tb_cpu_loader;

  logic        clk;
  logic        arst_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic        enable;
  logic        busy;
  logic        done;
  logic        error;

  cpu_loader #(.IMEM_ADDR_W(9), .DMEM_ADDR_W(10)) dut (
    .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .addr_ext(addr_ext), .wen_ext(wen_ext),
    .ren_ext(ren_ext), .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2),
    .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
    .enable(enable), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int done_cnt = 0;

  logic [63:0] qi_addr[$];
  logic [31:0] qi_data[$];
  logic [63:0] qd_addr[$];
  logic [63:0] qd_data[$];
  logic [31:0] pay[$];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Command-level model: from header and payload, list the writes that must appear.
  task automatic model_load(input logic [31:0] hdr, output bit exp_err);
    longint unsigned base, n;
    logic [1:0] cmd;
    cmd  = hdr[31:30];
    base = longint'(hdr[29:16]);
    n    = longint'(hdr[15:0]);
    exp_err = 1'b0;
    if (cmd == 2'b11) exp_err = 1'b1;
    else if (cmd == 2'b00 && n > 0) begin
      if ((base + n) * 4 > 512) exp_err = 1'b1;
      else for (longint unsigned i = 0; i < n; i++) begin
        qi_addr.push_back(64'((base + i) * 4));
        qi_data.push_back(pay[i]);
      end
    end else if (cmd == 2'b01 && n > 0) begin
      if ((base + n) * 8 > 1024) exp_err = 1'b1;
      else for (longint unsigned i = 0; i < n; i++) begin
        qd_addr.push_back(64'((base + i) * 8));
        qd_data.push_back({pay[2*i+1], pay[2*i]});
      end
    end
  endtask

  // Scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (wen_ext) begin
      if (qi_addr.size() == 0) chk("unexpected_wen_ext", 64'd1, 64'd0);
      else begin
        chk("imem_addr", addr_ext, qi_addr.pop_front());
        chk("imem_data", 64'(wdata_ext), 64'(qi_data.pop_front()));
      end
    end
    if (wen_ext_2) begin
      if (qd_addr.size() == 0) chk("unexpected_wen_ext_2", 64'd1, 64'd0);
      else begin
        chk("dmem_addr", addr_ext_2, qd_addr.pop_front());
        chk("dmem_data", wdata_ext_2, qd_data.pop_front());
      end
    end
    chk("wen_exclusive", 64'(wen_ext & wen_ext_2), 64'd0);
    chk("enable_vs_wen", 64'(enable & (wen_ext | wen_ext_2)), 64'd0);
    chk("ren_tied", 64'({ren_ext, ren_ext_2}), 64'd0);
    if (enable) chk("ready_low_in_run", 64'(s_ready), 64'd0);
    if (done) chk("done_without_enable", 64'(enable), 64'd0);
    if (enable) en_cnt++;
    if (done) done_cnt++;
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = w;
    for (int k = 0; k < 40; k++) begin
      if (s_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_addr_ext"}, addr_ext, 64'd0);
    chk({nm, "_addr_ext_2"}, addr_ext_2, 64'd0);
    chk({nm, "_wdata_ext"}, 64'(wdata_ext), 64'd0);
    chk({nm, "_wdata_ext_2"}, wdata_ext_2, 64'd0);
    chk({nm, "_ctrl"}, 64'({s_ready, wen_ext, wen_ext_2, ren_ext, ren_ext_2,
                            enable, busy, done, error}), 64'd0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check_all_zero(nm);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk({nm, "_ready_at_release"}, 64'(s_ready), 64'd0);
    settle();
    chk({nm, "_ready_after_release"}, 64'(s_ready), 64'd1);
  endtask

  // Drive a full load command through the model and the DUT.
  task automatic run_load(input string nm, input logic [31:0] hdr, input int gap);
    bit exp_err;
    model_load(hdr, exp_err);
    send(hdr, 0);
    if (!exp_err)
      foreach (pay[i]) send(pay[i], gap);
    settle();
    chk({nm, "_imem_drained"}, 64'(qi_addr.size()), 64'd0);
    chk({nm, "_dmem_drained"}, 64'(qd_addr.size()), 64'd0);
    chk({nm, "_error"}, 64'(error), 64'(exp_err));
    if (!exp_err) chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic expect_err_state(input string nm, input logic [31:0] hdr);
    bit exp_err;
    pay = {32'h0000_1111, 32'h0000_2222};
    model_load(hdr, exp_err);
    chk({nm, "_model_err"}, 64'(exp_err), 64'd1);
    send(hdr, 0);
    s_valid = 1'b1;
    s_data  = 32'h1234_5678;
    repeat (5) begin
      settle();
      chk({nm, "_error"}, 64'(error), 64'd1);
      chk({nm, "_ready"}, 64'(s_ready), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd1);
    end
    s_valid = 1'b0;
    qi_addr.delete(); qi_data.delete(); qd_addr.delete(); qd_data.delete();
    do_reset({nm, "_rst"});
  endtask

  initial begin
    bit e;
    arst_n  = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'd0;
    #1;
    check_all_zero("por");
    do_reset("reset0");

    // LOAD_I base=2 N=3 back-to-back; model pinned against hand values
    pay = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    model_load(32'h0002_0003, e);
    chk("pin_i_addr0", qi_addr[0], 64'd8);
    chk("pin_i_addr2", qi_addr[2], 64'd16);
    qi_addr.delete(); qi_data.delete();
    run_load("load_i", 32'h0002_0003, 0);

    // LOAD_D base=1 N=2 with s_valid gaps
    pay = {32'd1, 32'd2, 32'd3, 32'd4};
    model_load(32'h4001_0002, e);
    chk("pin_d_addr0", qd_addr[0], 64'd8);
    chk("pin_d_data1", qd_data[1], 64'h0000_0004_0000_0003);
    qd_addr.delete(); qd_data.delete();
    run_load("load_d", 32'h4001_0002, 2);

    // Range boundaries that just fit
    pay = {32'h5555_0001, 32'h5555_0002};
    run_load("load_i_edge", 32'h007E_0002, 0);
    pay = {32'h6666_0001, 32'h6666_0002};
    run_load("load_d_edge", 32'h407F_0001, 1);

    // RUN N=5
    en_cnt = 0; done_cnt = 0;
    send(32'h8000_0005, 0);
    #1;
    chk("run5_enable_rise", 64'(enable), 64'd1);
    chk("run5_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 20 && done_cnt == 0; k++) settle();
    chk("run5_enable_cycles", 64'(en_cnt), 64'd5);
    chk("run5_done_pulses", 64'(done_cnt), 64'd1);
    repeat (4) settle();
    chk("run5_done_once", 64'(done_cnt), 64'd1);
    chk("run5_idle", 64'(busy), 64'd0);
    chk("run5_ready", 64'(s_ready), 64'd1);

    // LOAD_I with N=0 is a no-op
    pay = {};
    run_load("load_i_n0", 32'h0000_0000, 0);
    chk("load_i_n0_ready", 64'(s_ready), 64'd1);

    // RUN N=0 runs until reset, then reset mid-run
    en_cnt = 0; done_cnt = 0;
    send(32'h8000_0000, 0);
    repeat (1100) @(negedge clk);
    #1;
    chk("run0_long", 64'(en_cnt >= 1100), 64'd1);
    chk("run0_enable", 64'(enable), 64'd1);
    chk("run0_no_done", 64'(done_cnt), 64'd0);
    do_reset("rst_mid_run");

    // Error cases
    expect_err_state("illegal_cmd", 32'hC000_0000);
    expect_err_state("imem_range", 32'h007F_0002);
    expect_err_state("dmem_range", 32'h4080_0001);

    // Reset after a LO beat, then a fresh LOAD_D must not see stale data
    send(32'h4000_0001, 0);
    send(32'hDEAD_BEEF, 0);
    settle();
    chk("mid_d_busy", 64'(busy), 64'd1);
    do_reset("rst_mid_load_d");
    pay = {32'h1111_1111, 32'h2222_2222};
    model_load(32'h4003_0001, e);
    chk("pin_fresh_d", qd_data[0], 64'h2222_2222_1111_1111);
    qd_addr.delete(); qd_data.delete();
    run_load("fresh_load_d", 32'h4003_0001, 0);

    repeat (3) settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
